wt_mem_req_arbiter: RTL and testbench

WT_MEM_REQ_ARBITER -- requirements
Module: wt_mem_req_arbiter

---
 rtl/wt_mem_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_wt_mem_req_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_req_arbiter.sv
// Arbitrates N cache-side requestors onto one memory request port, tracks in-flight
// transactions per port and routes memory returns back by the port index in the ID.
module wt_mem_req_arbiter #(
   parameter int NumPorts       = 3,
   parameter int TxIdWidth      = 4,
   parameter int MaxOutstanding = 4,
   parameter int ReqWidth       = 128,
   parameter int RtrnWidth      = 128,
   parameter int RrArb          = 1,
   localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1,
   localparam int CW = $clog2(MaxOutstanding + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clr_i,
   input  logic [NumPorts-1:0]           port_req_i,
   output logic [NumPorts-1:0]           port_ack_o,
   input  logic [NumPorts*ReqWidth-1:0]  port_data_i,
   input  logic [NumPorts*TxIdWidth-1:0] port_tid_i,
   output logic [NumPorts-1:0]           port_rtrn_vld_o,
   output logic [RtrnWidth-1:0]          port_rtrn_o,
   output logic [TxIdWidth-1:0]          port_rtrn_tid_o,
   output logic                          mem_req_o,
   input  logic                          mem_ack_i,
   output logic [ReqWidth-1:0]           mem_data_o,
   output logic [PW+TxIdWidth-1:0]       mem_tid_o,
   input  logic                          mem_rtrn_vld_i,
   input  logic [RtrnWidth-1:0]          mem_rtrn_i,
   input  logic [PW+TxIdWidth-1:0]       mem_rtrn_tid_i,
   output logic                          busy_o,
   output logic                          err_o
);

   localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

   logic [NumPorts-1:0][CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]               lock_port_q, lock_port_d;
   logic                        lock_q, lock_d;
   logic                        err_q, err_d;

   logic [NumPorts-1:0]  elig;
   logic [PW-1:0]        arb_idx, gnt_idx, rtrn_idx;
   logic                 arb_vld, req_vld, ack;
   logic                 rtrn_hit, rtrn_ok, cnt_nz;
   logic [ReqWidth-1:0]  gnt_data;
   logic [TxIdWidth-1:0] gnt_tid;
   int                   arb_try;

   // The in-flight limit only gates new grants; a locked port is held regardless.
   always_comb begin
      elig    = '0;
      arb_idx = '0;
      arb_vld = 1'b0;
      arb_try = 0;
      for (int p = 0; p < NumPorts; p++) begin
         elig[p] = port_req_i[p] && (cnt_q[p] < MaxCnt);
      end
      for (int i = 0; i < NumPorts; i++) begin
         arb_try = (RrArb != 0) ? (int'(rr_ptr_q) + i) % NumPorts : i;
         if (!arb_vld && elig[arb_try]) begin
            arb_vld = 1'b1;
            arb_idx = PW'(arb_try);
         end
      end
   end

   assign gnt_idx  = lock_q ? lock_port_q : arb_idx;
   assign req_vld  = rst_ni && (arb_vld || lock_q);
   assign ack      = req_vld && mem_ack_i;
   assign rtrn_idx = mem_rtrn_tid_i[PW+TxIdWidth-1:TxIdWidth];
   assign rtrn_ok  = rst_ni && mem_rtrn_vld_i && rtrn_hit;

   // Index compares keep out-of-range port numbers from addressing anything.
   always_comb begin
      gnt_data = '0;
      gnt_tid  = '0;
      rtrn_hit = 1'b0;
      cnt_nz   = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         if (gnt_idx == PW'(p)) begin
            gnt_data = port_data_i[p*ReqWidth +: ReqWidth];
            gnt_tid  = port_tid_i[p*TxIdWidth +: TxIdWidth];
         end
         if (rtrn_idx == PW'(p) && cnt_q[p] != '0) rtrn_hit = 1'b1;
         if (cnt_q[p] != '0) cnt_nz = 1'b1;
      end
   end

   always_comb begin
      port_ack_o      = '0;
      port_rtrn_vld_o = '0;
      for (int p = 0; p < NumPorts; p++) begin
         port_ack_o[p]      = ack && (gnt_idx == PW'(p));
         port_rtrn_vld_o[p] = rtrn_ok && (rtrn_idx == PW'(p));
      end
   end

   assign mem_req_o       = req_vld;
   assign mem_data_o      = rst_ni ? gnt_data : '0;
   assign mem_tid_o       = rst_ni ? {gnt_idx, gnt_tid} : '0;
   assign port_rtrn_o     = rst_ni ? mem_rtrn_i : '0;
   assign port_rtrn_tid_o = rst_ni ? mem_rtrn_tid_i[TxIdWidth-1:0] : '0;
   assign busy_o          = rst_ni && (cnt_nz || req_vld);
   assign err_o           = err_q;

   always_comb begin
      cnt_d       = cnt_q;
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      lock_port_d = lock_port_q;
      err_d       = err_q || (mem_rtrn_vld_i && !rtrn_ok);
      for (int p = 0; p < NumPorts; p++) begin
         if (port_ack_o[p] && !port_rtrn_vld_o[p]) begin
            cnt_d[p] = cnt_q[p] + CW'(1);
         end else if (port_rtrn_vld_o[p] && !port_ack_o[p]) begin
            cnt_d[p] = cnt_q[p] - CW'(1);
         end
      end
      if (ack) begin
         lock_d = 1'b0;
         if (RrArb != 0) begin
            rr_ptr_d = (int'(gnt_idx) == NumPorts - 1) ? '0 : gnt_idx + PW'(1);
         end
      end else if (req_vld && !lock_q) begin
         lock_d      = 1'b1;
         lock_port_d = gnt_idx;
      end
      // Returns seen during a clear are still routed above but not counted.
      if (clr_i) begin
         cnt_d       = '0;
         rr_ptr_d    = '0;
         lock_d      = 1'b0;
         lock_port_d = '0;
         err_d       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
         lock_q      <= 1'b0;
         lock_port_q <= '0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_q      <= lock_d;
         lock_port_q <= lock_port_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Bench for wt_mem_req_arbiter: a round-robin and a fixed-priority instance, each
// checked every cycle against a transaction-level model, plus directed scenarios.
module tb_wt_mem_req_arbiter;

   localparam int N    = 3;
   localparam int TW   = 4;
   localparam int DW   = 16;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst_n, clr;
   always #5 clk = ~clk;

   // index 0: round-robin instance, index 1: fixed-priority instance
   logic [N-1:0]    req    [2];
   logic [N*DW-1:0] data   [2];
   logic [N*TW-1:0] tid    [2];
   logic            mack   [2];
   logic            rvld   [2];
   logic [DW-1:0]   rdat   [2];
   logic [5:0]      rtid   [2];
   logic [N-1:0]    ack_o  [2];
   logic [N-1:0]    rvld_o [2];
   logic [DW-1:0]   rtrn_o [2];
   logic [TW-1:0]   rtid_o [2];
   logic            mreq   [2];
   logic [DW-1:0]   mdata  [2];
   logic [5:0]      mtid   [2];
   logic            busy   [2];
   logic            err    [2];

   for (genvar m = 0; m < 2; m++) begin : g_dut
      wt_mem_req_arbiter #(
         .NumPorts(N), .TxIdWidth(TW), .MaxOutstanding(MAXO),
         .ReqWidth(DW), .RtrnWidth(DW), .RrArb(m == 0 ? 1 : 0)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
         .port_req_i(req[m]), .port_ack_o(ack_o[m]),
         .port_data_i(data[m]), .port_tid_i(tid[m]),
         .port_rtrn_vld_o(rvld_o[m]), .port_rtrn_o(rtrn_o[m]), .port_rtrn_tid_o(rtid_o[m]),
         .mem_req_o(mreq[m]), .mem_ack_i(mack[m]),
         .mem_data_o(mdata[m]), .mem_tid_o(mtid[m]),
         .mem_rtrn_vld_i(rvld[m]), .mem_rtrn_i(rdat[m]), .mem_rtrn_tid_i(rtid[m]),
         .busy_o(busy[m]), .err_o(err[m])
      );
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, m, $time, act, exp);
      end
   endtask

   // Transaction-level model: outstanding count per port, next port in turn, held grant.
   int           mcnt [2][N];
   int           mrr  [2];
   bit           mlock[2];
   int           mlp  [2];
   bit           merr [2];
   logic [N-1:0] last_ack[2];

   task automatic model_reset(input int m);
      for (int p = 0; p < N; p++) mcnt[m][p] = 0;
      mrr[m] = 0; mlock[m] = 0; mlp[m] = 0; merr[m] = 0;
   endtask

   always @(negedge clk) begin : cmp
      int win, r, p;
      bit found, ok, anyc;
      logic [N-1:0] eack, evld;
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            chk("rst_mreq", m, 64'(mreq[m]), 0);
            chk("rst_ack", m, 64'(ack_o[m]), 0);
            chk("rst_rvld", m, 64'(rvld_o[m]), 0);
            chk("rst_busy", m, 64'(busy[m]), 0);
            chk("rst_err", m, 64'(err[m]), 0);
            chk("rst_data", m, 64'({mdata[m], mtid[m], rtrn_o[m], rtid_o[m]}), 0);
            model_reset(m);
            last_ack[m] = '0;
         end else begin
            found = 0; win = 0;
            if (mlock[m]) begin
               found = 1; win = mlp[m];
            end else begin
               for (int k = 0; k < N; k++) begin
                  p = (m == 0) ? (mrr[m] + k) % N : k;
                  if (!found && req[m][p] && mcnt[m][p] < MAXO) begin found = 1; win = p; end
               end
            end
            eack = (found && mack[m]) ? N'(1 << win) : '0;
            r  = int'(rtid[m][5:4]);
            ok = 0;
            if (rvld[m] && r < N) ok = (mcnt[m][r] > 0);
            evld = ok ? N'(1 << r) : '0;
            anyc = 0;
            for (int q = 0; q < N; q++) if (mcnt[m][q] > 0) anyc = 1;

            chk("mem_req", m, 64'(mreq[m]), 64'(found));
            chk("port_ack", m, 64'(ack_o[m]), 64'(eack));
            if (found) begin
               chk("mem_data", m, 64'(mdata[m]), 64'(data[m][win*DW +: DW]));
               chk("mem_tid", m, 64'(mtid[m]), 64'({2'(win), tid[m][win*TW +: TW]}));
            end
            chk("rtrn_vld", m, 64'(rvld_o[m]), 64'(evld));
            chk("rtrn_data", m, 64'(rtrn_o[m]), 64'(rdat[m]));
            chk("rtrn_tid", m, 64'(rtid_o[m]), 64'(rtid[m][3:0]));
            chk("busy", m, 64'(busy[m]), 64'(anyc || found));
            chk("err", m, 64'(err[m]), 64'(merr[m]));

            last_ack[m] = eack;
            if (clr) begin
               model_reset(m);
            end else begin
               if (rvld[m] && !ok) merr[m] = 1;
               if (ok) mcnt[m][r]--;
               if (eack != 0) begin
                  mcnt[m][win]++;
                  mlock[m] = 0;
                  if (m == 0) mrr[m] = (win + 1) % N;
               end else if (found && !mlock[m]) begin
                  mlock[m] = 1; mlp[m] = win;
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg;
      @(negedge clk);
   endtask

   task automatic clr_pulse;
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic rand_inputs(input int m);
      int p;
      for (int q = 0; q < N; q++) begin
         if (!(req[m][q] && !last_ack[m][q])) begin
            if ($urandom_range(0, 99) < 45) begin
               req[m][q] = 1'b1;
               data[m][q*DW +: DW] = DW'($urandom);
               tid[m][q*TW +: TW]  = TW'($urandom);
            end else begin
               req[m][q] = 1'b0;
            end
         end
      end
      mack[m] = ($urandom_range(0, 99) < 60);
      rvld[m] = 1'b0;
      rdat[m] = DW'($urandom);
      rtid[m] = 6'($urandom);
      if ($urandom_range(0, 99) < 50) begin
         p = $urandom_range(0, N - 1);
         if (mcnt[m][p] > 0 || $urandom_range(0, 99) < 4) begin
            rvld[m] = 1'b1;
            rtid[m] = {2'(p), TW'($urandom)};
         end else if ($urandom_range(0, 99) < 3) begin
            rvld[m] = 1'b1;
            rtid[m] = {2'd3, TW'($urandom)};
         end
      end
   endtask

   logic [N-1:0] aseq [4];
   logic [1:0]   pseq [4];

   initial begin
      aseq = '{3'b001, 3'b010, 3'b100, 3'b001};
      pseq = '{2'd0, 2'd1, 2'd2, 2'd0};
      rst_n = 1'b0; clr = 1'b0;
      for (int m = 0; m < 2; m++) begin
         req[m] = '0; mack[m] = 1'b0; rvld[m] = 1'b0; rdat[m] = '0; rtid[m] = '0;
         for (int q = 0; q < N; q++) begin
            data[m][q*DW +: DW] = DW'(16'h1000 * (q + 1) + m);
            tid[m][q*TW +: TW]  = TW'(q + 3);
         end
      end
      req[0] = 3'b111;
      mack[0] = 1'b1;
      #1;
      chk("lit_rst_gate_req", 0, 64'(mreq[0]), 0);
      at_neg();
      tick();
      req[0] = '0; mack[0] = 1'b0;
      rst_n = 1'b1;

      // Round-robin rotation with all ports requesting and memory always ready
      req[0] = 3'b111; mack[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("lit_rr_ack", i, 64'(ack_o[0]), 64'(aseq[i]));
         chk("lit_rr_port", i, 64'(mtid[0][5:4]), 64'(pseq[i]));
         tick();
      end
      req[0] = '0; mack[0] = 1'b0;
      clr_pulse();

      // Fixed priority: a held grant is not preempted by port 0
      req[1] = 3'b100; mack[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("lit_fp_hold_ack", i, 64'(ack_o[1]), 0);
         chk("lit_fp_hold_port", i, 64'(mtid[1][5:4]), 2);
         tick();
      end
      req[1] = 3'b101; mack[1] = 1'b1;
      at_neg();
      chk("lit_fp_nopreempt", 1, 64'(ack_o[1]), 64'(3'b100));
      tick();
      req[1] = 3'b001;
      at_neg();
      chk("lit_fp_next", 1, 64'(ack_o[1]), 64'(3'b001));
      tick();
      req[1] = '0; mack[1] = 1'b0;
      clr_pulse();

      // Outstanding limit and return routing
      req[0] = 3'b010; mack[0] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         at_neg();
         chk("lit_lim_ack", i, 64'(ack_o[0]), 64'(3'b010));
         tick();
      end
      at_neg();
      chk("lit_lim_block", 0, 64'(mreq[0]), 0);
      tick();
      rvld[0] = 1'b1; rtid[0] = 6'b01_0101;
      at_neg();
      chk("lit_rtrn_vld", 0, 64'(rvld_o[0]), 64'(3'b010));
      chk("lit_rtrn_tid", 0, 64'(rtid_o[0]), 5);
      chk("lit_rtrn_same_cyc", 0, 64'(mreq[0]), 0);
      tick();
      rvld[0] = 1'b0;
      at_neg();
      chk("lit_lim_reopen", 0, 64'(ack_o[0]), 64'(3'b010));
      tick();
      req[0] = '0; mack[0] = 1'b0;
      clr_pulse();

      // Ack and return to the same port in one cycle
      req[0] = 3'b001; mack[0] = 1'b1;
      at_neg();
      tick();
      rvld[0] = 1'b1; rtid[0] = 6'b00_0010;
      at_neg();
      chk("lit_same_ack", 0, 64'(ack_o[0]), 64'(3'b001));
      chk("lit_same_rvld", 0, 64'(rvld_o[0]), 64'(3'b001));
      tick();
      req[0] = '0; mack[0] = 1'b0; rvld[0] = 1'b0;
      at_neg();
      chk("lit_same_busy", 0, 64'(busy[0]), 1);
      tick();
      rvld[0] = 1'b1; rtid[0] = 6'b00_0000;
      at_neg();
      chk("lit_same_drain", 0, 64'(rvld_o[0]), 64'(3'b001));
      tick();
      rvld[0] = 1'b0;
      at_neg();
      chk("lit_same_idle", 0, 64'(busy[0]), 0);
      tick();

      // Return with nothing outstanding
      rvld[0] = 1'b1; rtid[0] = 6'b10_0000;
      at_neg();
      chk("lit_err_novld", 0, 64'(rvld_o[0]), 0);
      tick();
      rvld[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         at_neg();
         chk("lit_err_sticky", i, 64'(err[0]), 1);
         tick();
      end
      clr_pulse();
      at_neg();
      chk("lit_err_clr", 0, 64'(err[0]), 0);
      chk("lit_clr_busy", 0, 64'(busy[0]), 0);
      tick();

      // Asynchronous reset while a grant is locked
      req[0] = 3'b001; mack[0] = 1'b1;
      at_neg();
      tick();
      req[0] = 3'b010; mack[0] = 1'b0;
      at_neg();
      chk("lit_lock_req", 0, 64'(mreq[0]), 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("lit_arst_mreq", 0, 64'(mreq[0]), 0);
      chk("lit_arst_busy", 0, 64'(busy[0]), 0);
      chk("lit_arst_tid", 0, 64'(mtid[0]), 0);
      at_neg();
      tick();
      rst_n = 1'b1; req[0] = 3'b111; mack[0] = 1'b1;
      at_neg();
      chk("lit_arst_restart", 0, 64'(ack_o[0]), 64'(3'b001));
      tick();
      req[0] = '0; mack[0] = 1'b0;
      clr_pulse();

      // Randomized traffic on both instances
      for (int it = 0; it < 3000; it++) begin
         rand_inputs(0);
         rand_inputs(1);
         clr = ($urandom_range(0, 199) == 0);
         tick();
      end
      clr = 1'b0;
      at_neg();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
